// File: rtl/aes_round_scheduler.sv
// aes_round_scheduler
//   Iterative controller for a shared combinational AES round datapath.
//   Owns the 128-bit state register, the round counter and the mode latch,
//   and walks one round per clock: ADDKEY (rnd 0), MID (1..Nr-1), LAST (Nr).
//   Encryption uses round keys 0..Nr; decryption uses Nr..0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   block input handshake; in_data, in_decrypt sampled on accept
//   abort               synchronous cancel, overrides everything
//   dp_state            state register driven to the datapath
//   dp_round_type       0 ADDKEY, 1 MID, 2 LAST
//   dp_decrypt          latched mode
//   dp_key_idx          round-key select, 0..Nr
//   dp_result           combinational datapath result for the current round
//   out_valid/out_ready result handshake; out_data is the state register
//   busy                high while a block is in flight or held for output
//   done_count          completed-block counter (wraps)
module aes_round_scheduler #(
   parameter int unsigned Nr     = 10,
   parameter int unsigned KIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_data,
   input  logic              in_decrypt,
   input  logic              abort,
   output logic [127:0]      dp_state,
   output logic [1:0]        dp_round_type,
   output logic              dp_decrypt,
   output logic [KIDX_W-1:0] dp_key_idx,
   input  logic [127:0]      dp_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_data,
   output logic              busy,
   output logic [15:0]       done_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0]        RT_ADDKEY = 2'd0;
   localparam logic [1:0]        RT_MID    = 2'd1;
   localparam logic [1:0]        RT_LAST   = 2'd2;
   localparam logic [KIDX_W-1:0] NR_K      = KIDX_W'(Nr);

   state_t              fsm_q, fsm_d;
   logic [127:0]        blk_q, blk_d;
   logic [KIDX_W-1:0]   rnd_q, rnd_d;
   logic                mode_q, mode_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= S_IDLE;
         blk_q  <= '0;
         rnd_q  <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         fsm_q  <= fsm_d;
         blk_q  <= blk_d;
         rnd_q  <= rnd_d;
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
      end
   end

   // Next state and handshake outputs. abort wins over every state and also
   // suppresses both handshakes so no block is taken or delivered that cycle.
   always_comb begin
      fsm_d     = fsm_q;
      blk_d     = blk_q;
      rnd_d     = rnd_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;

      if (abort) begin
         fsm_d = S_IDLE;
         blk_d = '0;
         rnd_d = '0;
      end else begin
         case (fsm_q)
            S_IDLE: begin
               in_ready = 1'b1;
               accept   = in_valid;
            end
            S_ROUND: begin
               blk_d = dp_result;
               rnd_d = rnd_q + 1'b1;
               if (rnd_q == NR_K) begin
                  fsm_d = S_DONE;
                  rnd_d = '0;
               end
            end
            S_DONE: begin
               out_valid = 1'b1;
               // a waiting block may enter on the same cycle the result leaves
               in_ready  = out_ready;
               if (out_ready) begin
                  cnt_d = cnt_q + 16'd1;
                  if (in_valid) accept = 1'b1;
                  else          fsm_d  = S_IDLE;
               end
            end
            default: fsm_d = S_IDLE;
         endcase

         if (accept) begin
            fsm_d  = S_ROUND;
            blk_d  = in_data;
            mode_d = in_decrypt;
            rnd_d  = '0;
         end
      end
   end

   // Datapath controls come from registers only, so the datapath never sees
   // a combinational path from the handshake inputs.
   always_comb begin
      dp_round_type = RT_ADDKEY;
      dp_key_idx    = '0;
      if (fsm_q == S_ROUND) begin
         if (rnd_q == '0)        dp_round_type = RT_ADDKEY;
         else if (rnd_q == NR_K) dp_round_type = RT_LAST;
         else                    dp_round_type = RT_MID;
         dp_key_idx = mode_q ? (NR_K - rnd_q) : rnd_q;
      end
   end

   assign dp_state   = blk_q;
   assign dp_decrypt = mode_q;
   assign out_data   = blk_q;
   assign busy       = (fsm_q != S_IDLE);
   assign done_count = cnt_q;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// tb_aes_round_scheduler
//   Drives aes_round_scheduler (Nr=10) against a golden AES-128 round
//   datapath built in the bench, compares every cycle with a block-level
//   model, and runs directed scenarios with hand-computed expectations.
module tb_aes_round_scheduler;

   localparam int NR = 10;
   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_decrypt = 1'b0;
   logic         abort = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_ready;
   logic [127:0] dp_state;
   logic [1:0]   dp_round_type;
   logic         dp_decrypt;
   logic [3:0]   dp_key_idx;
   logic [127:0] dp_result;
   logic         out_valid;
   logic [127:0] out_data;
   logic         busy;
   logic [15:0]  done_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0]   sbox [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk [NR+1];

   int exp_tseq [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
   int exp_kdec [11] = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
   int exp_kenc [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

   aes_round_scheduler #(.Nr(10), .KIDX_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_decrypt    (in_decrypt),
      .abort         (abort),
      .dp_state      (dp_state),
      .dp_round_type (dp_round_type),
      .dp_decrypt    (dp_decrypt),
      .dp_key_idx    (dp_key_idx),
      .dp_result     (dp_result),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .busy          (busy),
      .done_count    (done_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- AES reference functions ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = '0; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [127:0] sub_b(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = inv ? isbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] shift_r(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      int src;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
         end
      return o;
   endfunction

   function automatic logic [127:0] mix_c(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [7:0] cf [4];
      logic [7:0] acc;
      if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
      else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(s[127-8*(j+4*c) -: 8], cf[(j - r + 4) % 4]);
            o[127-8*(r+4*c) -: 8] = acc;
         end
      return o;
   endfunction

   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [1:0] t,
                                             input logic dec, input logic [3:0] idx);
      logic [127:0] k;
      if (int'(idx) > NR) return '0;
      k = rk[idx];
      case (t)
         2'd0:    return s ^ k;
         2'd1:    return dec ? mix_c(sub_b(shift_r(s, 1'b1), 1'b1) ^ k, 1'b1)
                             : mix_c(shift_r(sub_b(s, 1'b0), 1'b0), 1'b0) ^ k;
         2'd2:    return dec ? sub_b(shift_r(s, 1'b1), 1'b1) ^ k
                             : shift_r(sub_b(s, 1'b0), 1'b0) ^ k;
         default: return '0;
      endcase
   endfunction

   function automatic logic [1:0] rtype(input int a);
      return (a == 0) ? 2'd0 : ((a == NR) ? 2'd2 : 2'd1);
   endfunction

   function automatic logic [3:0] kidx(input int a, input logic dec);
      return dec ? 4'(NR - a) : 4'(a);
   endfunction

   function automatic logic [127:0] aes_block(input logic [127:0] blk, input logic dec);
      logic [127:0] s;
      s = blk;
      for (int r = 0; r <= NR; r++) s = round_fn(s, rtype(r), dec, kidx(r, dec));
      return s;
   endfunction

   // golden datapath seen by the DUT
   assign dp_result = round_fn(dp_state, dp_round_type, dp_decrypt, dp_key_idx);

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- block-level model ----------------
   // age: -1 idle, 0..NR round in progress, NR+1 result waiting
   int           age = -1;
   logic [127:0] m_state = '0;
   logic [127:0] m_exp = '0;
   logic         m_mode = 1'b0;
   logic [15:0]  m_count = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age <= -1; m_state <= '0; m_mode <= 1'b0; m_count <= '0;
      end else if (abort) begin
         age <= -1; m_state <= '0;
      end else if (age <= NR && age >= 0) begin
         m_state <= round_fn(m_state, rtype(age), m_mode, kidx(age, m_mode));
         age     <= age + 1;
      end else if (age < 0 || out_ready) begin
         if (age > NR) m_count <= m_count + 16'd1;
         if (in_valid) begin
            age <= 0; m_state <= in_data; m_mode <= in_decrypt;
            m_exp <= aes_block(in_data, in_decrypt);
         end else begin
            age <= -1;
         end
      end
   end

   always @(negedge clk) begin : cmp
      logic e_rdy, e_ov;
      if (rst_n) begin
         e_rdy = !abort && (age < 0 || (age == NR + 1 && out_ready));
         e_ov  = !abort && (age == NR + 1);
         chk("in_ready",   128'(in_ready),   128'(e_rdy));
         chk("out_valid",  128'(out_valid),  128'(e_ov));
         chk("busy",       128'(busy),       128'(age >= 0));
         chk("done_count", 128'(done_count), 128'(m_count));
         chk("dp_state",   dp_state,         m_state);
         if (age >= 0 && age <= NR) begin
            chk("dp_round_type", 128'(dp_round_type), 128'(rtype(age)));
            chk("dp_key_idx",    128'(dp_key_idx),    128'(kidx(age, m_mode)));
            chk("dp_decrypt",    128'(dp_decrypt),    128'(m_mode));
         end else if (age < 0) begin
            chk("idle_round_type", 128'(dp_round_type), 128'(0));
            chk("idle_key_idx",    128'(dp_key_idx),    128'(0));
         end
         if (age == NR + 1) chk("out_data", out_data, m_exp);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic wait_valid(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (out_valid) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("out_valid_timeout", 128'(0), 128'(1));
   endtask

   task automatic record_seq(input int exp_k [11], input string nm);
      logic [3:0] ks [11];
      logic [1:0] ts [11];
      for (int i = 0; i <= NR; i++) begin
         @(negedge clk);
         ks[i] = dp_key_idx;
         ts[i] = dp_round_type;
      end
      for (int i = 0; i <= NR; i++) begin
         chk({nm, "_key_seq"},  128'(ks[i]), 128'(exp_k[i]));
         chk({nm, "_type_seq"}, 128'(ts[i]), 128'(exp_tseq[i]));
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_in_ready"},   128'(in_ready),      128'(1));
      chk({nm, "_out_valid"},  128'(out_valid),     128'(0));
      chk({nm, "_busy"},       128'(busy),          128'(0));
      chk({nm, "_done_count"}, 128'(done_count),    128'(0));
      chk({nm, "_dp_state"},   dp_state,            128'(0));
      chk({nm, "_key_idx"},    128'(dp_key_idx),    128'(0));
      chk({nm, "_round_type"}, 128'(dp_round_type), 128'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin : stim
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  inv, rcon;
      int t0, t1, t2;
      bit seen;

      for (int x = 0; x < 256; x++) begin
         inv = '0;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         isbox[sbox[x]] = 8'(x);
      end
      for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

      // pin the reference model to published values
      chk("model_sbox00", 128'(sbox[0]),     128'(8'h63));
      chk("model_sbox53", 128'(sbox[8'h53]), 128'(8'hed));
      chk("model_rk1",    rk[1],  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      chk("model_rk10",   rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("model_enc",    aes_block(PT, 1'b0), CT);
      chk("model_dec",    aes_block(CT, 1'b1), PT);

      #1 check_reset_outputs("reset");
      #11 rst_n = 1'b1;
      tick;

      // decrypt with backpressure
      in_valid = 1'b1; in_data = CT; in_decrypt = 1'b1; out_ready = 1'b0;
      tick; t0 = cyc;
      in_valid = 1'b0; in_decrypt = 1'b0; in_data = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
      record_seq(exp_kdec, "dec");
      wait_valid(20, t1);
      chk("dec_latency", 128'(t1 - t0), 128'(11));
      chk("dec_result",  out_data, PT);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_data",   out_data, PT);
         chk("bp_in_ready",   128'(in_ready), 128'(0));
         chk("bp_done_count", 128'(done_count), 128'(0));
      end
      tick; out_ready = 1'b1;
      tick; out_ready = 1'b0;
      @(negedge clk);
      chk("bp_release_count", 128'(done_count), 128'(1));

      // encrypt; in_decrypt toggled mid-block must be ignored
      tick;
      in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0; out_ready = 1'b1;
      tick; t0 = cyc;
      in_valid = 1'b0; in_decrypt = 1'b1;
      record_seq(exp_kenc, "enc");
      wait_valid(20, t1);
      chk("enc_latency", 128'(t1 - t0), 128'(11));
      chk("enc_result",  out_data, CT);
      tick;
      @(negedge clk);
      chk("enc_count", 128'(done_count), 128'(2));

      // back-to-back: second block accepted on the output handshake
      tick;
      in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0; out_ready = 1'b1;
      tick; t0 = cyc;
      in_data = CT; in_decrypt = 1'b1;
      wait_valid(30, t1);
      chk("b2b_first_latency", 128'(t1 - t0), 128'(11));
      chk("b2b_first_result",  out_data, CT);
      tick;
      in_valid = 1'b0;
      wait_valid(30, t2);
      chk("b2b_spacing",       128'(t2 - t1), 128'(12));
      chk("b2b_second_result", out_data, PT);
      tick;
      @(negedge clk);
      chk("b2b_count", 128'(done_count), 128'(4));

      // abort at round 5
      tick;
      in_valid = 1'b1; in_data = CT; in_decrypt = 1'b1; out_ready = 1'b0;
      tick;
      in_valid = 1'b0;
      repeat (5) tick;
      abort = 1'b1;
      @(negedge clk);
      chk("abort_at_round5_key", 128'(dp_key_idx), 128'(5));
      tick;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy",      128'(busy), 128'(0));
      chk("abort_state",     dp_state, 128'(0));
      chk("abort_count",     128'(done_count), 128'(4));
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_out_valid", 128'(seen), 128'(0));
      tick;
      abort = 1'b1; in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0;
      @(negedge clk);
      chk("abort_blocks_accept", 128'(in_ready), 128'(0));
      tick;
      abort = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("abort_not_taken", 128'(busy), 128'(0));
      tick;
      in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0; out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      wait_valid(20, t1);
      chk("post_abort_result", out_data, CT);
      tick;
      @(negedge clk);
      chk("post_abort_count", 128'(done_count), 128'(5));

      // asynchronous reset mid-round
      tick;
      in_valid = 1'b1; in_data = CT; in_decrypt = 1'b1; out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      repeat (4) tick;
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick;
      in_valid = 1'b1; in_data = CT; in_decrypt = 1'b1;
      tick;
      in_valid = 1'b0;
      wait_valid(20, t1);
      chk("post_reset_result", out_data, PT);
      tick;
      @(negedge clk);
      chk("post_reset_count", 128'(done_count), 128'(1));

      repeat (2) tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_round_scheduler.md
Name: aes_round_scheduler

Overview:
- Iterative controller that sequences a shared, combinational AES round datapath for both encryption and decryption.
- Owns the 128-bit state register, the round counter and the round-key index.
- Accepts blocks over a valid/ready input, drives the datapath one round per cycle, and presents results over a valid/ready output.
- Sits between the block-level wrapper and the AddRoundKey / round / last-round logic and the expanded key schedule.

Parameters:
- Nr, 10, number of AES rounds; legal values 10, 12, 14.
- KIDX_W, 4, width of the round-key index; must satisfy 2^KIDX_W > Nr.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  scheduler can accept a block.
- in_data  in  128  input block (ciphertext or plaintext).
- in_decrypt  in  1  1 = decrypt, 0 = encrypt; sampled with in_data.
- abort  in  1  synchronous cancel of the current block.
- dp_state  out  128  current state driven to the datapath.
- dp_round_type  out  2  0 = ADDKEY, 1 = MID, 2 = LAST; 3 is never driven.
- dp_decrypt  out  1  latched mode for the datapath.
- dp_key_idx  out  KIDX_W  selects round key 0..Nr from the expanded schedule.
- dp_result  in  128  combinational datapath result for the current round.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  128  result block; equals the state register.
- busy  out  1  high in ROUND or DONE.
- done_count  out  16  completed-block counter.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; state register, rnd, mode, dp_key_idx and done_count all 0.
  - out_valid=0, busy=0, in_ready=1.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state register <= in_data, mode <= in_decrypt, rnd <= 0, go to ROUND.
- ROUND:
  - in_ready=0; dp_state = state register.
  - Round type: rnd==0 is ADDKEY; 1..Nr-1 is MID; rnd==Nr is LAST.
  - dp_key_idx = rnd when encrypting, Nr-rnd when decrypting (decrypt key order is Nr, Nr-1, ..., 0).
  - Every cycle: state register <= dp_result, rnd <= rnd+1.
  - After the LAST cycle, go to DONE.
- DONE:
  - out_valid=1 and out_data is held stable until out_ready.
  - On out_ready: done_count increments (wraps from FFFF to 0).
  - If in_valid is also high on that cycle, accept the new block directly (in_ready = out_ready in DONE) and go to ROUND.
  - Otherwise go to IDLE.
- Latency:
  - Acceptance edge T; out_valid is high from edge T+Nr+1.
  - For Nr=10 this is 11 cycles; throughput is 1 block per Nr+2 cycles at full rate.
- abort:
  - Highest priority in any state: next state IDLE, out_valid=0, state register cleared to 0, rnd=0, done_count unchanged.
  - abort with in_valid on the same cycle: the block is not accepted (in_ready is forced to 0 while abort=1).
- The datapath must be idle-safe: in IDLE, dp_round_type=ADDKEY, dp_key_idx=0, dp_state=state register.
- Mode and key ordering are frozen for the whole block; in_decrypt changes during ROUND are ignored.
- rst_n assertion mid-block discards the block immediately; after release the scheduler accepts a fresh block with no residual state.
- No combinational path from in_valid or out_ready to dp_* outputs.

Test Plan:
- Decrypt, key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a, with a golden datapath model -> out_data 00112233445566778899aabbccddeeff; out_valid rises exactly 11 cycles after acceptance; dp_key_idx sequence 10,9,...,0; dp_round_type sequence 0, 1×9, 2.
- Encrypt, same key, in_data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; dp_key_idx sequence 0..10.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, done_count unchanged; on release done_count=1.
- Back-to-back: in_valid held high, out_ready=1 -> the second block is accepted on the DONE handshake cycle; two correct results 12 cycles apart; done_count=2.
- abort asserted at round 5 -> IDLE the next cycle, out_valid never asserted, done_count=0; the next block completes correctly.
- rst_n pulsed low mid-ROUND (asynchronously, between edges) -> all outputs at reset values immediately; a subsequent block decrypts correctly.
